// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// controller states and default widths.
`timescale 1ns/1ps
package mul_div_unit_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 6;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } md_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Operand, MTHI/MTLO and result bundle between the datapath and the
// multiply/divide unit.
`timescale 1ns/1ps
interface mul_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, A, B, hi_we, lo_we, wdata,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, A, B, hi_we, lo_we, wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mul_div_unit_sign_fix.sv
// Conditional two's-complement negate of a value pair; in wide mode the pair
// is treated as one double-width value controlled by neg_lo_i.
`timescale 1ns/1ps
module md_sign_fix
    import mul_div_unit_pkg::*;
#(
    parameter int W = MD_WIDTH
) (
    input  logic [W-1:0] val_hi_i,
    input  logic [W-1:0] val_lo_i,
    input  logic         neg_hi_i,
    input  logic         neg_lo_i,
    input  logic         wide_i,
    output logic [W-1:0] res_hi_o,
    output logic [W-1:0] res_lo_o
);
    logic [2*W-1:0] full;
    logic [2*W-1:0] full_res;

    assign full     = {val_hi_i, val_lo_i};
    assign full_res = neg_lo_i ? -full : full;

    assign res_hi_o = wide_i ? full_res[2*W-1:W] : (neg_hi_i ? -val_hi_i : val_hi_i);
    assign res_lo_o = wide_i ? full_res[W-1:0]   : (neg_lo_i ? -val_lo_i : val_lo_i);
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes allowed
// RUN   | one shift-add / shift-subtract iteration per edge
// FIX   | sign correction, HI/LO write, done pulse
`timescale 1ns/1ps
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_div_unit_if.slave  bus
);
    md_state_e        state_q, state_d;
    md_op_e           op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] wk_q, wk_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             neg_hi_q, neg_hi_d;
    logic             neg_lo_q, neg_lo_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             in_signed, in_div, run_div;
    logic [WIDTH-1:0] mag_a, mag_b, fix_hi, fix_lo;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic             div_ge;

    assign in_signed = op_is_signed(bus.op);
    assign in_div    = op_is_div(bus.op);
    assign run_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);

    md_sign_fix #(.W(WIDTH)) u_mag (
        .val_hi_i (bus.A),
        .val_lo_i (bus.B),
        .neg_hi_i (in_signed & bus.A[WIDTH-1]),
        .neg_lo_i (in_signed & bus.B[WIDTH-1]),
        .wide_i   (1'b0),
        .res_hi_o (mag_a),
        .res_lo_o (mag_b)
    );

    md_sign_fix #(.W(WIDTH)) u_fix (
        .val_hi_i (acc_q),
        .val_lo_i (wk_q),
        .neg_hi_i (neg_hi_q),
        .neg_lo_i (neg_lo_q),
        .wide_i   (~run_div),
        .res_hi_o (fix_hi),
        .res_lo_o (fix_lo)
    );

    // Multiply: {acc, wk} is the product register, multiplier shifts out of wk.
    assign mul_sum   = {1'b0, acc_q} + (wk_q[0] ? {1'b0, mcand_q} : '0);
    // Divide: partial remainder < divisor always, so diff MSB is a clean borrow.
    assign div_shift = {acc_q, wk_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mcand_q};
    assign div_ge    = ~div_diff[WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= OP_MULT;
            cnt_q      <= '0;
            acc_q      <= '0;
            wk_q       <= '0;
            mcand_q    <= '0;
            neg_hi_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            wk_q       <= wk_d;
            mcand_q    <= mcand_d;
            neg_hi_q   <= neg_hi_d;
            neg_lo_q   <= neg_lo_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        wk_d       = wk_q;
        mcand_d    = mcand_q;
        neg_hi_d   = neg_hi_q;
        neg_lo_d   = neg_lo_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                if (bus.start) begin
                    op_d     = md_op_e'(bus.op);
                    cnt_d    = '0;
                    acc_d    = '0;
                    neg_hi_d = 1'b0;
                    neg_lo_d = 1'b0;
                    if (in_div && (bus.B == '0)) begin
                        // Pass-through in FIX leaves hi = dividend, lo = all ones.
                        state_d    = FIX;
                        div_zero_d = 1'b1;
                        acc_d      = bus.A;
                        wk_d       = '1;
                        mcand_d    = '0;
                    end else begin
                        state_d    = RUN;
                        div_zero_d = 1'b0;
                        neg_lo_d   = in_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        neg_hi_d   = in_signed & bus.A[WIDTH-1];
                        wk_d       = in_div ? mag_a : mag_b;
                        mcand_d    = in_div ? mag_b : mag_a;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (run_div) begin
                    acc_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    wk_d  = {wk_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    wk_d  = {mul_sum[0], wk_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
            end
            FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table, random ops against a
// behavioural model, and hand-written busy/reset/back-to-back sequences.
`timescale 1ns/1ps
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } sb_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    sb_t  sb[$];
    vec_t vecs[15];

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic sb_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        sb_t r;
        longint sa, sb_, p, q, m;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        r.dz = 1'b0;
        case (op)
            OP_MULT:  begin p = sa * sb_; r.hi = p[63:32]; r.lo = p[31:0]; end
            OP_MULTU: begin up = {32'b0, a} * {32'b0, b}; r.hi = up[63:32]; r.lo = up[31:0]; end
            OP_DIV: begin
                if (b == 32'd0) begin r.dz = 1'b1; r.hi = a; r.lo = 32'hFFFFFFFF; end
                else begin q = sa / sb_; m = sa % sb_; r.hi = m[31:0]; r.lo = q[31:0]; end
            end
            default: begin
                if (b == 32'd0) begin r.dz = 1'b1; r.hi = a; r.lo = 32'hFFFFFFFF; end
                else begin r.hi = a % b; r.lo = a / b; end
            end
        endcase
        return r;
    endfunction

    // Caller is at a negedge; the following posedge is the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic hwe, input logic [31:0] wd, input logic push,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        sb_t e;
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.hi_we = hwe;
        bus.wdata = wd;
        if (push) begin
            e.hi = ehi; e.lo = elo; e.dz = edz;
            sb.push_back(e);
        end
    endtask

    // Called at the negedge just after the accept edge.
    task automatic finish_op(input string name, input int exp_lat, input int inj_start, input int inj_we);
        int  lat;
        int  busy_cnt;
        sb_t e;
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        lat       = 1;
        busy_cnt  = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (lat == inj_start) begin bus.start = 1'b1; bus.op = OP_DIVU; bus.A = 32'd9; bus.B = 32'd3; end
            if (lat == inj_we) begin bus.lo_we = 1'b1; bus.wdata = 32'hAA; end
            @(negedge clk);
            bus.start = 1'b0;
            bus.lo_we = 1'b0;
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
        chk({name, "_busy_in_done"}, 64'(bus.busy), 64'd0);
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_scoreboard: actual empty required one entry", name);
        end else begin
            e = sb.pop_front();
            chk({name, "_hi"}, 64'(bus.hi), 64'(e.hi));
            chk({name, "_lo"}, 64'(bus.lo), 64'(e.lo));
            chk({name, "_div_zero"}, 64'(bus.div_zero), 64'(e.dz));
        end
    endtask

    initial begin
        int   seen;
        sb_t  m;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
        vecs[3]  = '{OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0, 34};
        vecs[4]  = '{OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 2};
        vecs[5]  = '{OP_MULTU, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0, 34};
        vecs[6]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 34};
        vecs[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
        vecs[8]  = '{OP_MULT,  32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 1'b0, 34};
        vecs[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 34};
        vecs[10] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 34};
        vecs[11] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34};
        vecs[12] = '{OP_DIVU,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 2};
        vecs[13] = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 34};
        vecs[14] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2,        1'b0, 34};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.A     = '0;
        bus.B     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_div_zero", 64'(bus.div_zero), 64'd0);
        chk("reset_hi", 64'(bus.hi), 64'd0);
        chk("reset_lo", 64'(bus.lo), 64'd0);
        rst_n = 1'b1;

        bus.hi_we = 1'b1; bus.wdata = 32'h12345678;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h9ABCDEF0;
        @(negedge clk);
        bus.lo_we = 1'b0;
        chk("mthi_idle", 64'(bus.hi), 64'h12345678);
        chk("mtlo_idle", 64'(bus.lo), 64'h9ABCDEF0);

        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, '0, 1'b1, vecs[i].hi, vecs[i].lo, vecs[i].dz);
            @(negedge clk);
            finish_op($sformatf("vec%0d", i), vecs[i].lat, -1, -1);
            @(negedge clk);
            chk($sformatf("vec%0d_done_one_cycle", i), 64'(bus.done), 64'd0);
        end

        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            m   = model(rop, ra, rb);
            issue(rop, ra, rb, 1'b0, '0, 1'b1, m.hi, m.lo, m.dz);
            @(negedge clk);
            finish_op($sformatf("rnd%0d", i), (rop[1] && rb == 0) ? 2 : 34, -1, -1);
        end

        // MTHI in the accept edge lands, then the op's result overwrites it.
        @(negedge clk);
        issue(OP_MULTU, 32'd2, 32'd3, 1'b1, 32'hDEAD, 1'b1, 32'd0, 32'd6, 1'b0);
        @(negedge clk);
        chk("mthi_with_start", 64'(bus.hi), 64'hDEAD);
        chk("mthi_with_start_busy", 64'(bus.busy), 64'd1);
        finish_op("mthi_overwrite", 34, -1, -1);

        // Start and MTLO during busy are dropped; start in the done cycle is taken.
        @(negedge clk);
        issue(OP_MULTU, 32'd3, 32'd4, 1'b0, '0, 1'b1, 32'd0, 32'd12, 1'b0);
        @(negedge clk);
        finish_op("busy_ignore", 34, 10, 12);
        issue(OP_DIVU, 32'd9, 32'd3, 1'b0, '0, 1'b1, 32'd0, 32'd3, 1'b0);
        @(negedge clk);
        chk("b2b_accept_busy", 64'(bus.busy), 64'd1);
        chk("b2b_accept_done", 64'(bus.done), 64'd0);
        finish_op("b2b", 34, -1, -1);

        // Reset in the middle of a DIV aborts it with no done pulse.
        @(negedge clk);
        issue(OP_DIV, 32'd100, 32'd7, 1'b0, '0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_hi", 64'(bus.hi), 64'd0);
        chk("abort_lo", 64'(bus.lo), 64'd0);
        chk("abort_div_zero", 64'(bus.div_zero), 64'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'd0);

        issue(OP_DIVU, 32'd100, 32'd7, 1'b0, '0, 1'b1, 32'd2, 32'd14, 1'b0);
        @(negedge clk);
        finish_op("after_abort", 34, -1, -1);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
